// File: rtl/dmem_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_RD_LAT = 3;
  localparam int DEF_WR_LAT = 2;

  // The counter never holds more than max_lat-1, so clog2(max_lat) bits suffice.
  function automatic int lat_cnt_w(input int max_lat);
    return (max_lat < 2) ? 1 : $clog2(max_lat);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read of the same address.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: storage arrays carry no reset; clearing them would force flops instead of RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side MEM-stage responder with fixed read/write latency and a one-cycle response pulse.
// Optional one-entry last-load buffer enabled by defining DMEM_RD_BUF_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int WR_LAT = DEF_WR_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam int                CNT_W     = lat_cnt_w((RD_LAT > WR_LAT) ? RD_LAT : WR_LAT);
  localparam logic [CNT_W-1:0]  RD_CNT    = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  WR_CNT    = CNT_W'(WR_LAT - 1);
  localparam logic              RD_ONE    = (RD_LAT == 1);
  localparam logic              WR_ONE    = (WR_LAT == 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_live;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_err;

  logic               w_accept;
  logic               w_commit;
  logic               w_cur_we;
  logic [ADDR_W-1:0]  w_cur_addr;
  logic [DATA_W-1:0]  w_cur_wdata;
  logic               w_in_range;
  logic               w_lat_one;
  logic               w_hit;
  logic               w_arr_we;
  logic [DATA_W-1:0]  w_arr_rdata;
  logic [DATA_W-1:0]  w_rsp_data;

  assign w_accept = req_valid && req_ready;

  // A latency-1 or buffer-hit request commits on its accept edge, before the latch holds it.
  assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_in_range  = {1'b0, w_cur_addr} < DEPTH_LIM;
  assign w_lat_one   = w_cur_we ? WR_ONE : RD_ONE;
  assign w_arr_we    = w_commit && w_cur_we && w_in_range;

`ifdef DMEM_RD_BUF_EN
  logic               r_buf_valid;
  logic [ADDR_W-1:0]  r_buf_tag;
  logic [DATA_W-1:0]  r_buf_data;

  assign w_hit      = (r_state == IDLE) && !w_cur_we && w_in_range &&
                      r_buf_valid && (r_buf_tag == w_cur_addr);
  assign w_rsp_data = w_hit ? r_buf_data : w_arr_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
    end else if (w_commit && w_in_range) begin
      if (!w_cur_we) begin
        r_buf_valid <= 1'b1;
        r_buf_tag   <= w_cur_addr;
        r_buf_data  <= w_rsp_data;
      end else if (r_buf_valid && (r_buf_tag == w_cur_addr)) begin
        r_buf_data  <= w_cur_wdata;
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_rsp_data = w_arr_rdata;
`endif

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_addr  (w_cur_addr[IDX_W-1:0]),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_arr_rdata)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_hit || w_lat_one) begin
            w_state_nxt = RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = w_cur_we ? WR_CNT : RD_CNT;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_commit    = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_live  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_commit) begin
        r_err   <= !w_in_range;
        r_rdata <= (w_cur_we || !w_in_range) ? '0 : w_rsp_data;
      end
    end
  end

  assign req_ready = r_live && (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : '0;
  assign rsp_err   = rsp_valid && r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; buffer expectations follow DMEM_RD_BUF_EN.
module tb_dmem_responder;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          n_acc    = 0;
  int          n_rsp    = 0;
  logic [15:0] mem_m [int];
`ifdef DMEM_RD_BUF_EN
  logic        buf_v = 1'b0;
  logic [15:0] buf_tag = '0;
`endif

  dmem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pops one expectation per rsp_valid pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          n_rsp++;
          check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, mon_e.rdata});
          check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
          check("rsp_latency", cyc - mon_e.acc_cyc + 1, mon_e.lat);
        end
      end else begin
        check("rdata_idle_zero", {16'd0, rsp_rdata}, 32'd0);
        check("err_idle_zero", {31'd0, rsp_err}, 32'd0);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rdata"}, {16'd0, rsp_rdata}, 32'd0);
    check({tag, "_err"},   {31'd0, rsp_err},   32'd0);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_assert");
    repeat (cycles) @(negedge clk);
    check_outputs_zero("rst_held");
    rst = 1'b0;
    sb.delete();
`ifdef DMEM_RD_BUF_EN
    buf_v = 1'b0;
`endif
    #1;
    check("ready_at_release", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_release", {31'd0, req_ready}, 32'd1);
  endtask

  // Drive one request; keep=0 means the response is expected to be dropped.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata, input bit keep);
    exp_t e;
    int   waited;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    e.err     = (addr >= 16'(DEPTH));
    e.rdata   = 16'h0000;
    e.lat     = we ? WR_LAT : RD_LAT;
    e.acc_cyc = cyc + 1;
    if (keep && !e.err) begin
      if (we) begin
        mem_m[int'(addr)] = wdata;
      end else begin
        e.rdata = mem_m.exists(int'(addr)) ? mem_m[int'(addr)] : 16'h0000;
`ifdef DMEM_RD_BUF_EN
        if (buf_v && buf_tag == addr) e.lat = 1;
        buf_v   = 1'b1;
        buf_tag = addr;
`endif
      end
    end
    if (keep) begin
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("ready_after_accept", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rsp_drained", sb.size(), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    issue(we, addr, wdata, 1'b1);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    do_reset(2);

    // Basic store then load.
    txn(1'b1, 16'h0000, 16'h1111);
    txn(1'b1, 16'h0010, 16'hBEEF);
    txn(1'b0, 16'h0010, 16'h0000);

    // Range boundaries: last valid word, first invalid word, top of address space.
    txn(1'b1, 16'h03FF, 16'h7777);
    txn(1'b0, 16'h03FF, 16'h0000);
    txn(1'b0, 16'h0400, 16'h0000);
    txn(1'b1, 16'h0400, 16'hDEAD);
    txn(1'b0, 16'h0000, 16'h0000);
    txn(1'b0, 16'hFFFF, 16'h0000);

    // Requests held during WAIT must be ignored.
    txn(1'b1, 16'h0030, 16'h3030);
    txn(1'b1, 16'h0031, 16'h3131);
    issue(1'b0, 16'h0030, 16'h0000, 1'b1);
    req_we    = 1'b1;
    req_addr  = 16'h0031;
    req_wdata = 16'hBAD0;
    req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("ignore_not_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    wait_idle();
    txn(1'b0, 16'h0031, 16'h0000);

    // Reset during a store: the store must never land.
    txn(1'b1, 16'h0020, 16'h5555);
    issue(1'b1, 16'h0020, 16'h1234, 1'b0);
    do_reset(1);
    txn(1'b0, 16'h0020, 16'h0000);

    // Repeated loads, write-through store, unrelated store, out-of-range load.
    txn(1'b1, 16'h0005, 16'h0505);
    txn(1'b0, 16'h0005, 16'h0000);
    txn(1'b0, 16'h0005, 16'h0000);
    txn(1'b1, 16'h0005, 16'h00AA);
    txn(1'b0, 16'h0005, 16'h0000);
    txn(1'b1, 16'h0006, 16'h0606);
    txn(1'b0, 16'h0005, 16'h0000);
    txn(1'b0, 16'h0400, 16'h0000);
    txn(1'b0, 16'h0005, 16'h0000);
    txn(1'b0, 16'h0006, 16'h0000);

    // Randomised in-range traffic over a small address window.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a;
      a = 16'h0040 + 16'($urandom_range(0, 3));
      if (!mem_m.exists(int'(a)) || ($urandom_range(0, 1) == 1))
        txn(1'b1, a, 16'($urandom_range(0, 65535)));
      else
        txn(1'b0, a, 16'h0000);
    end

    check("one_rsp_per_accept", n_rsp, n_acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
